// File: rtl/twos_neg_arbiter.sv
// Round-robin arbiter in front of one shared bit-serial two's complement negator.
// Operands are negated LSB-first: copy through the first 1, invert every bit above it.
module twos_neg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_flat,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [WIDTH-1:0]      y,
  output logic                  y_valid,
  output logic [IDW-1:0]        y_id,
  output logic                  ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MNEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [NREQ-1:0]  ONE  = {{(NREQ-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, sel, idx, id;
  logic             found;
  logic [WIDTH-1:0] sel_a, opnd, res;
  logic [CW-1:0]    cnt;
  logic             seen1, mneg, out_bit, last;

  // Scan upward from the pointer; NREQ is a power of two so the index wraps for free.
  always_comb begin
    sel   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + IDW'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign sel_a   = a_flat[sel*WIDTH +: WIDTH];
  assign out_bit = seen1 ? ~opnd[0] : opnd[0];
  assign last    = (cnt == CW'(WIDTH-1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant   <= '0;
      busy    <= 1'b0;
      y       <= '0;
      y_valid <= 1'b0;
      y_id    <= '0;
      ovf     <= 1'b0;
      ptr     <= '0;
      id      <= '0;
      opnd    <= '0;
      res     <= '0;
      cnt     <= '0;
      seen1   <= 1'b0;
      mneg    <= 1'b0;
    end else begin
      grant   <= '0;
      y_valid <= 1'b0;
      ovf     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant <= ONE << sel;
            opnd  <= sel_a;
            mneg  <= (sel_a == MNEG);
            id    <= sel;
            cnt   <= '0;
            seen1 <= 1'b0;
            busy  <= 1'b1;
            ptr   <= sel + 1'b1;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so the word is aligned after WIDTH shifts.
          opnd  <= opnd >> 1;
          seen1 <= seen1 | opnd[0];
          res   <= {out_bit, res[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (last) begin
            y       <= {out_bit, res[WIDTH-1:1]};
            y_id    <= id;
            y_valid <= 1'b1;
            ovf     <= mneg;
          end
        end
        DONE:    busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_twos_neg_arbiter.sv
// Randomized and directed bench for twos_neg_arbiter against a transaction-level model.
module tb_twos_neg_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;
  localparam logic [WIDTH-1:0] MNEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] a_flat = '0;
  logic [NREQ-1:0]       grant;
  logic                  busy, y_valid, ovf;
  logic [WIDTH-1:0]      y;
  logic [IDW-1:0]        y_id;

  int errs = 0, chks = 0, cyc = 0;
  bit chk_on = 1'b0;

  twos_neg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .grant(grant), .busy(busy),
    .y(y), .y_valid(y_valid), .y_id(y_id), .ovf(ovf));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a transaction timer counts edges since the accept; outputs follow from it.
  int               mt, mptr;
  logic [NREQ-1:0]  mgrant;
  logic             mbusy, mvalid, movf, mneg;
  logic [WIDTH-1:0] my, mres;
  logic [IDW-1:0]   mid, mcur;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  function automatic logic [WIDTH-1:0] opnd_of(input int i);
    return a_flat[i*WIDTH +: WIDTH];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mt <= -1; mptr <= 0; mgrant <= '0; mbusy <= 1'b0; mvalid <= 1'b0;
      movf <= 1'b0; my <= '0; mid <= '0; mres <= '0; mcur <= '0; mneg <= 1'b0;
    end else if (mt < 0) begin
      mgrant <= '0;
      if (req != '0) begin
        mgrant <= NREQ'(1 << rr_pick(req, mptr));
        mcur   <= IDW'(rr_pick(req, mptr));
        mres   <= -opnd_of(rr_pick(req, mptr));
        mneg   <= (opnd_of(rr_pick(req, mptr)) == MNEG);
        mptr   <= (rr_pick(req, mptr) + 1) % NREQ;
        mt     <= 0;
        mbusy  <= 1'b1;
      end
    end else begin
      mgrant <= '0;
      mt     <= mt + 1;
      if (mt + 1 == WIDTH) begin
        my <= mres; mid <= mcur; movf <= mneg; mvalid <= 1'b1;
      end else if (mt + 1 == WIDTH + 1) begin
        mvalid <= 1'b0; movf <= 1'b0; mbusy <= 1'b0; mt <= -1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("grant", 32'(grant), 32'(mgrant));
      chk("busy", 32'(busy), 32'(mbusy));
      chk("y_valid", 32'(y_valid), 32'(mvalid));
      chk("y", 32'(y), 32'(my));
      chk("y_id", 32'(y_id), 32'(mid));
      chk("ovf", 32'(ovf), 32'(movf));
    end
  end

  // Transaction logs used by the literal checks.
  int gq_id[$], gq_cyc[$], vq_cyc[$];
  logic [WIDTH+IDW:0] vq[$];
  always @(negedge clk) begin
    if (grant != '0) begin
      for (int k = 0; k < NREQ; k++) if (grant[k]) gq_id.push_back(k);
      gq_cyc.push_back(cyc);
    end
    if (y_valid) begin
      vq.push_back({ovf, y_id, y});
      vq_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    gq_id.delete(); gq_cyc.delete(); vq.delete(); vq_cyc.delete();
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (grant != '0) begin ok = 1'b1; return; end
    end
  endtask

  task automatic run_one(input int i, input logic [WIDTH-1:0] v);
    bit ok;
    @(negedge clk);
    a_flat[i*WIDTH +: WIDTH] = v;
    req[i] = 1'b1;
    wait_grant(ok);
    req[i] = 1'b0;
    chk("grant_seen", 32'(ok), 32'd1);
    repeat (WIDTH + 2) @(negedge clk);
  endtask

  task automatic chk_result(input string nm, input int k, input logic [WIDTH-1:0] ey,
                            input int eid, input bit eovf);
    if (vq.size() <= k) begin
      chk({nm, "_present"}, 32'(vq.size()), 32'(k + 1));
    end else begin
      chk({nm, "_y"}, 32'(vq[k][WIDTH-1:0]), 32'(ey));
      chk({nm, "_id"}, 32'(vq[k][WIDTH+IDW-1:WIDTH]), 32'(eid));
      chk({nm, "_ovf"}, 32'(vq[k][WIDTH+IDW]), 32'(eovf));
    end
  endtask

  initial begin
    bit ok;
    int n;
    #1 rst = 1'b1;
    #1 chk_on = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_y", 32'(y), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Single requester, latency and busy drop
    clear_logs();
    run_one(0, 8'h0A);
    chk_result("t1", 0, 8'hF6, 0, 1'b0);
    if (gq_id.size() == 1 && vq_cyc.size() == 1) begin
      chk("t1_gid", 32'(gq_id[0]), 32'd0);
      chk("t1_latency", 32'(vq_cyc[0] - gq_cyc[0]), 32'(WIDTH));
    end else chk("t1_counts", 32'(gq_id.size() + vq_cyc.size()), 32'd2);
    chk("t1_busy_low", 32'(busy), 32'd0);

    // Boundary operands on requester 2
    clear_logs();
    run_one(2, 8'hF6);
    run_one(2, 8'h00);
    run_one(2, 8'h80);
    chk_result("t2a", 0, 8'h0A, 2, 1'b0);
    chk_result("t2b", 1, 8'h00, 2, 1'b0);
    chk_result("t2c", 2, 8'h80, 2, 1'b1);

    // All requesting from a fresh pointer
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    clear_logs();
    a_flat = {8'h04, 8'h03, 8'h02, 8'h01};
    req = 4'hF;
    n = 0;
    while (gq_id.size() < 5 && n < 80) begin @(negedge clk); n++; end
    req = '0;
    chk("t3_timeout", 32'(n < 80), 32'd1);
    repeat (WIDTH + 3) @(negedge clk);
    if (gq_id.size() == 5) begin
      chk("t3_g0", 32'(gq_id[0]), 32'd0);
      chk("t3_g1", 32'(gq_id[1]), 32'd1);
      chk("t3_g2", 32'(gq_id[2]), 32'd2);
      chk("t3_g3", 32'(gq_id[3]), 32'd3);
      chk("t3_g4", 32'(gq_id[4]), 32'd0);
      for (int k = 0; k < 4; k++) chk("t3_spacing", 32'(gq_cyc[k+1] - gq_cyc[k]), 32'(WIDTH + 2));
    end else chk("t3_grants", 32'(gq_id.size()), 32'd5);
    chk_result("t3r0", 0, 8'hFF, 0, 1'b0);
    chk_result("t3r1", 1, 8'hFE, 1, 1'b0);
    chk_result("t3r2", 2, 8'hFD, 2, 1'b0);
    chk_result("t3r3", 3, 8'hFC, 3, 1'b0);

    // Pointer wrap: bring pointer to 2, then requesters 0 and 1 together
    run_one(1, 8'h55);
    clear_logs();
    @(negedge clk);
    a_flat[0 +: WIDTH] = 8'h11;
    a_flat[WIDTH +: WIDTH] = 8'h22;
    req = 4'b0011;
    n = 0;
    while (req != '0 && n < 60) begin
      @(negedge clk);
      if (grant[0]) req[0] = 1'b0;
      if (grant[1]) req[1] = 1'b0;
      n++;
    end
    req = '0;
    repeat (WIDTH + 3) @(negedge clk);
    if (gq_id.size() == 2) begin
      chk("t4_g0", 32'(gq_id[0]), 32'd0);
      chk("t4_g1", 32'(gq_id[1]), 32'd1);
    end else chk("t4_grants", 32'(gq_id.size()), 32'd2);
    chk_result("t4r0", 0, 8'hEF, 0, 1'b0);
    chk_result("t4r1", 1, 8'hDE, 1, 1'b0);

    // Asynchronous reset at the fourth RUN edge
    clear_logs();
    @(negedge clk);
    a_flat[0 +: WIDTH] = 8'h40;
    req[0] = 1'b1;
    wait_grant(ok);
    req[0] = 1'b0;
    chk("t5_grant_seen", 32'(ok), 32'd1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_y", 32'(y), 32'd0);
    chk("t5_yv", 32'(y_valid), 32'd0);
    chk("t5_yid", 32'(y_id), 32'd0);
    chk("t5_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);
    chk("t5_no_valid", 32'(vq.size()), 32'd0);
    a_flat[3*WIDTH +: WIDTH] = 8'h01;
    req[3] = 1'b1;
    wait_grant(ok);
    chk("t5_grant3", 32'(grant), 32'b1000);
    req = '0;
    repeat (WIDTH + 2) @(negedge clk);
    chk_result("t5r", 0, 8'hFF, 3, 1'b0);

    // Operand churn after accept; request withdrawn while busy
    clear_logs();
    @(negedge clk);
    a_flat[WIDTH +: WIDTH] = 8'h37;
    req[1] = 1'b1;
    wait_grant(ok);
    req[1] = 1'b0;
    for (int k = 0; k < WIDTH + 2; k++) begin
      a_flat = {$urandom, $urandom};
      @(negedge clk);
    end
    chk_result("t6a", 0, 8'hC9, 1, 1'b0);
    clear_logs();
    run_one(0, 8'h01);
    clear_logs();
    @(negedge clk);
    req[0] = 1'b1;
    wait_grant(ok);
    req[0] = 1'b0;
    req[2] = 1'b1;
    repeat (3) @(negedge clk);
    req[2] = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);
    chk("t6_one_grant", 32'(gq_id.size()), 32'd1);
    chk("t6_one_valid", 32'(vq.size()), 32'd1);

    // Random traffic, biased toward the boundary operands
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 5))
          0:       a_flat[i*WIDTH +: WIDTH] = '0;
          1:       a_flat[i*WIDTH +: WIDTH] = MNEG;
          default: a_flat[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        endcase
      end
    end
    req = '0;
    repeat (WIDTH + 4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule

// File: doc/twos_neg_arbiter.md
Name: twos_neg_arbiter

Overview:
- Shares one bit-serial two's complement (negation) engine among NREQ requesters.
- Arbitration is round-robin.
- Each accepted operand is negated LSB-first over WIDTH cycles using the "copy up to and including the first 1, invert the rest" rule.
- The registered result is returned tagged with the requester index.
- Sits between multiple producer blocks and their consumers wherever 8-bit negation is needed at low area.

Parameters:
NREQ, 4, number of requesters (power of two, >=2)
WIDTH, 8, operand/result width in bits
IDW, 2, requester id width = log2(NREQ)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request level; held until grant
a_flat  input  NREQ*WIDTH  operands; requester i drives a_flat[i*WIDTH +: WIDTH]
grant  output  NREQ  one-hot, one-cycle pulse: operand of that requester captured
busy  output  1  high from accept edge until the edge after y_valid
y  output  WIDTH  result (-a mod 2^WIDTH); holds until next result
y_valid  output  1  one-cycle pulse, y/y_id/ovf valid
y_id  output  IDW  requester index of current y
ovf  output  1  set with y_valid when operand was most negative (1 followed by zeros), i.e. y == a and a != 0

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=IDLE; grant, y, y_valid, y_id, ovf, busy all 0.
  - Round-robin pointer=0 (requester 0 highest priority).
  - In-flight operand discarded, no y_valid produced.
- All outputs registered.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any req bit is set, on the edge (E0):
    - Select the first set req scanning from pointer upward, wrapping modulo NREQ.
    - grant<=onehot(sel); capture operand into shift register; id<=sel.
    - cnt<=0, seen1<=0, busy<=1, pointer<=(sel+1) mod NREQ, state<=RUN.
  - Otherwise remain in IDLE, grant=0.
- RUN:
  - grant<=0 at E1.
  - Each edge En (n=1..WIDTH) processes operand bit n-1:
    - out = seen1 ? ~bit : bit
    - seen1 <= seen1 | bit
  - Result bit shifts in MSB-first into the result register, so it is aligned after WIDTH shifts.
  - On edge E_WIDTH (cnt==WIDTH-1):
    - y<=result, y_id<=id, y_valid<=1.
    - ovf<=(operand MSB==1 && lower bits==0).
    - state<=DONE.
- DONE: next edge y_valid<=0, ovf<=0, busy<=0, state<=IDLE.
- Latency and throughput:
  - Accept edge to y_valid: WIDTH edges; y_valid is high in the cycle after E_WIDTH.
  - Next accept at the earliest on E_WIDTH+2, giving a throughput of 1 result per WIDTH+2 cycles.
- Requests:
  - req is sampled only in IDLE.
  - Requests arriving during RUN/DONE wait; dropping req before grant forfeits the request with no side effect.
  - Operand changes after the accept edge do not affect the result.
- Arithmetic boundary cases:
  - Zero operand -> y=0, ovf=0.
  - Most negative operand -> y=operand, ovf=1.
  - All other operands -> y = (~a)+1 truncated to WIDTH.
- Simultaneous requests: exactly one grant per accept; the others stay pending and are served in rotating order, with no starvation (each requester served within NREQ transactions).
- req rising in the same cycle as DONE is not granted until the IDLE edge that follows.

Test Plan:
- Requester 0 only, a=00001010 -> grant=0001 at E0, y=11110110, y_id=0, ovf=0, y_valid pulse 8 edges after accept, busy low after next edge.
- Requester 2, a=11110110 -> y=00001010, y_id=2; then a=00000000 -> y=00000000, ovf=0; then a=10000000 -> y=10000000, ovf=1.
- All four req held high with distinct operands (01h,02h,03h,04h) -> grants in order 0,1,2,3,0; y_ids 0,1,2,3 with y=FFh,FEh,FDh,FCh; accepts exactly 10 cycles apart.
- Pointer at 2, req=0011 -> requester 0 granted before 1 (wrap-around), then pointer=1 grants 1.
- Assert rst during RUN at E4 -> all outputs 0 immediately (before next clk), no y_valid; after release, req=1000 -> grant 1000 (pointer reset to 0 but only req3 set).
- Change a_flat of granted requester every cycle after accept -> y equals negation of value captured at accept edge; req dropped before grant -> no grant, no y_valid.
